// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - accumulator/status sequencer driving a combinational ALU
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   req_valid/req_ready             operation handshake (accept = valid && ready)
//   req_kind, req_operand           operation code and memory operand M
//   p_load_en/p_load_data           direct P write, IDLE only
//   a_load_en/a_load_data           direct A write, IDLE only (updates N/Z)
//   alu_reg_a/b, alu_op,            registered ALU drive
//   alu_carry_in, alu_decimal_mode
//   alu_hold_reg, alu_carry_out,    ALU result inputs
//   alu_overflow
//   acc, status, done               A, P (NV1BDIZC), commit pulse
module alu_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [3:0] req_kind,
  input  logic [7:0] req_operand,
  input  logic       p_load_en,
  input  logic [7:0] p_load_data,
  input  logic       a_load_en,
  input  logic [7:0] a_load_data,
  output logic [7:0] alu_reg_a,
  output logic [7:0] alu_reg_b,
  output logic [4:0] alu_op,
  output logic       alu_carry_in,
  output logic       alu_decimal_mode,
  input  logic [7:0] alu_hold_reg,
  input  logic       alu_overflow,
  input  logic       alu_carry_out,
  output logic [7:0] acc,
  output logic [7:0] status,
  output logic       done
);

  localparam logic [4:0] OP_NONE = 5'b00000;
  localparam logic [4:0] OP_SUM  = 5'b10000;
  localparam logic [4:0] OP_AND  = 5'b01000;
  localparam logic [4:0] OP_OR   = 5'b00100;
  localparam logic [4:0] OP_EOR  = 5'b00010;
  localparam logic [4:0] OP_SR   = 5'b00001;

  localparam logic [3:0] K_ADC = 4'd0,  K_SBC = 4'd1,  K_AND = 4'd2,  K_ORA = 4'd3;
  localparam logic [3:0] K_EOR = 4'd4,  K_CMP = 4'd5,  K_ASL = 4'd6,  K_LSR = 4'd7;
  localparam logic [3:0] K_ROL = 4'd8,  K_ROR = 4'd9,  K_INC = 4'd10, K_DEC = 4'd11;

  typedef enum logic [1:0] {IDLE, S1, S2} state_t;

  state_t     state;
  logic [7:0] a_reg;
  logic [7:0] p_reg;
  logic [3:0] kind_q;
  logic [7:0] m_q;
  logic [7:0] a0_q;
  logic       c1_q;

  logic       accept;
  logic [7:0] a_src;
  logic [7:0] s1_a;
  logic [7:0] s1_b;
  logic [4:0] s1_op;
  logic       two_step;
  logic [7:0] res;
  logic [7:0] b_eff;
  logic       wr_a;
  logic [7:0] p_next;
  logic       unused_ok;

  assign req_ready        = (state == IDLE) && !p_load_en;
  assign accept           = req_valid && req_ready;
  assign acc              = a_reg;
  assign status           = p_reg | 8'h20;
  assign alu_carry_in     = p_reg[0];
  assign alu_decimal_mode = 1'b0;
  assign unused_ok        = alu_overflow;

  // An A load coincident with an accept is applied first, so the op sees it.
  assign a_src = a_load_en ? a_load_data : a_reg;

  assign two_step = (kind_q == K_ADC) || (kind_q == K_SBC) ||
                    (kind_q == K_ROL) || (kind_q == K_ROR);

  // First-step ALU drive, decoded from the incoming request.
  always_comb begin
    s1_a  = a_src;
    s1_b  = 8'h00;
    s1_op = OP_NONE;
    case (req_kind)
      K_ADC:        begin s1_b = req_operand;  s1_op = OP_SUM; end
      K_SBC, K_CMP: begin s1_b = ~req_operand; s1_op = OP_SUM; end
      K_AND:        begin s1_b = req_operand;  s1_op = OP_AND; end
      K_ORA:        begin s1_b = req_operand;  s1_op = OP_OR;  end
      K_EOR:        begin s1_b = req_operand;  s1_op = OP_EOR; end
      K_ASL, K_ROL: begin s1_b = a_src;        s1_op = OP_SUM; end
      K_LSR, K_ROR: begin                      s1_op = OP_SR;  end
      K_INC:        begin s1_b = 8'h01;        s1_op = OP_SUM; end
      K_DEC:        begin s1_b = 8'hFF;        s1_op = OP_SUM; end
      default:      begin s1_a = 8'h00; end
    endcase
  end

  // Commit values from the final step's ALU result.
  always_comb begin
    res    = alu_hold_reg;
    b_eff  = (kind_q == K_SBC) ? ~m_q : m_q;
    wr_a   = 1'b0;
    p_next = p_reg;
    case (kind_q)
      K_ADC, K_SBC: begin
        wr_a      = 1'b1;
        p_next[0] = c1_q | alu_carry_out;
        // Overflow from operand/result signs: per-step ALU V is meaningless here.
        p_next[6] = ~(a0_q[7] ^ b_eff[7]) & (a0_q[7] ^ res[7]);
      end
      K_AND, K_ORA, K_EOR, K_INC, K_DEC: wr_a = 1'b1;
      K_CMP: begin
        // ALU produced A0 + ~M; the +1 of the subtraction is added here.
        res       = alu_hold_reg + 8'h01;
        p_next[0] = alu_carry_out | (&alu_hold_reg);
      end
      K_ASL: begin wr_a = 1'b1; p_next[0] = alu_carry_out; end
      K_LSR, K_ROR: begin wr_a = 1'b1; p_next[0] = a0_q[0]; end
      K_ROL: begin wr_a = 1'b1; p_next[0] = a0_q[7]; end
      default: ;
    endcase
    if (kind_q <= K_DEC) begin
      p_next[7] = res[7];
      p_next[1] = (res == 8'h00);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_reg     <= 8'h00;
      p_reg     <= 8'h20;
      kind_q    <= 4'h0;
      m_q       <= 8'h00;
      a0_q      <= 8'h00;
      c1_q      <= 1'b0;
      alu_reg_a <= 8'h00;
      alu_reg_b <= 8'h00;
      alu_op    <= OP_NONE;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (p_load_en) begin
            p_reg <= p_load_data;
          end else if (a_load_en) begin
            p_reg[7] <= a_load_data[7];
            p_reg[1] <= (a_load_data == 8'h00);
          end
          if (a_load_en) a_reg <= a_load_data;
          if (accept) begin
            kind_q    <= req_kind;
            m_q       <= req_operand;
            a0_q      <= a_src;
            alu_reg_a <= s1_a;
            alu_reg_b <= s1_b;
            alu_op    <= s1_op;
            state     <= S1;
          end
        end
        S1: begin
          if (two_step) begin
            c1_q      <= alu_carry_out;
            alu_reg_a <= alu_hold_reg;
            alu_reg_b <= (kind_q == K_ROR) ? {p_reg[0], 7'b0} : {7'b0, p_reg[0]};
            alu_op    <= (kind_q == K_ROR) ? OP_OR : OP_SUM;
            state     <= S2;
          end else begin
            if (wr_a) a_reg <= res;
            p_reg     <= p_next;
            done      <= 1'b1;
            alu_reg_a <= 8'h00;
            alu_reg_b <= 8'h00;
            alu_op    <= OP_NONE;
            state     <= IDLE;
          end
        end
        default: begin
          if (wr_a) a_reg <= res;
          p_reg     <= p_next;
          done      <= 1'b1;
          alu_reg_a <= 8'h00;
          alu_reg_b <= 8'h00;
          alu_op    <= OP_NONE;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - self-checking bench for alu_seq
module tb_alu_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [3:0] req_kind = 4'h0;
  logic [7:0] req_operand = 8'h00;
  logic       p_load_en = 1'b0;
  logic [7:0] p_load_data = 8'h00;
  logic       a_load_en = 1'b0;
  logic [7:0] a_load_data = 8'h00;
  logic [7:0] alu_reg_a, alu_reg_b;
  logic [4:0] alu_op;
  logic       alu_carry_in, alu_decimal_mode;
  logic [7:0] alu_hold_reg;
  logic       alu_overflow, alu_carry_out;
  logic [7:0] acc, status;
  logic       done;

  int errors = 0;
  int checks = 0;
  logic [7:0] m_a = 8'h00;
  logic [7:0] m_p = 8'h20;

  always #5 clk = ~clk;

  alu_seq dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_kind(req_kind), .req_operand(req_operand),
    .p_load_en(p_load_en), .p_load_data(p_load_data),
    .a_load_en(a_load_en), .a_load_data(a_load_data),
    .alu_reg_a(alu_reg_a), .alu_reg_b(alu_reg_b), .alu_op(alu_op),
    .alu_carry_in(alu_carry_in), .alu_decimal_mode(alu_decimal_mode),
    .alu_hold_reg(alu_hold_reg), .alu_overflow(alu_overflow),
    .alu_carry_out(alu_carry_out),
    .acc(acc), .status(status), .done(done)
  );

  // Combinational ALU: SUM ignores carry-in, SR returns carry 0.
  always_comb begin
    alu_hold_reg  = 8'h00;
    alu_carry_out = 1'b0;
    alu_overflow  = 1'b0;
    case (alu_op)
      5'b10000: begin
        {alu_carry_out, alu_hold_reg} = {1'b0, alu_reg_a} + {1'b0, alu_reg_b};
        alu_overflow = (alu_reg_a[7] == alu_reg_b[7]) && (alu_hold_reg[7] != alu_reg_a[7]);
      end
      5'b01000: alu_hold_reg = alu_reg_a & alu_reg_b;
      5'b00100: alu_hold_reg = alu_reg_a | alu_reg_b;
      5'b00010: alu_hold_reg = alu_reg_a ^ alu_reg_b;
      5'b00001: alu_hold_reg = {1'b0, alu_reg_a[7:1]};
      default: ;
    endcase
  end

  function automatic int sgn(input int x);
    return (x > 127) ? x - 256 : x;
  endfunction

  // Architectural reference: 6502-style accumulator semantics in integer arithmetic.
  task automatic ref_op(input logic [3:0] k, input logic [7:0] m, output int lat);
    int a, mv, c, u, sr;
    logic [7:0] r;
    logic cb;
    bit nz, wa;
    a = int'(m_a); mv = int'(m); cb = m_p[0]; c = cb ? 1 : 0;
    r = m_a; nz = 1; wa = 1; lat = 2;
    case (k)
      4'd0: begin
        u = a + mv + c; r = u[7:0]; m_p[0] = (u > 255);
        sr = sgn(a) + sgn(mv) + c; m_p[6] = (sr > 127) || (sr < -128); lat = 3;
      end
      4'd1: begin
        u = a - mv - (1 - c); r = u[7:0]; m_p[0] = (u >= 0);
        sr = sgn(a) - sgn(mv) - (1 - c); m_p[6] = (sr > 127) || (sr < -128); lat = 3;
      end
      4'd2: r = m_a & m;
      4'd3: r = m_a | m;
      4'd4: r = m_a ^ m;
      4'd5: begin r = m_a - m; m_p[0] = (a >= mv); wa = 0; end
      4'd6: begin r = {m_a[6:0], 1'b0}; m_p[0] = m_a[7]; end
      4'd7: begin r = {1'b0, m_a[7:1]}; m_p[0] = m_a[0]; end
      4'd8: begin r = {m_a[6:0], cb}; m_p[0] = m_a[7]; lat = 3; end
      4'd9: begin r = {cb, m_a[7:1]}; m_p[0] = m_a[0]; lat = 3; end
      4'd10: r = m_a + 8'd1;
      4'd11: r = m_a - 8'd1;
      default: begin nz = 0; wa = 0; end
    endcase
    if (wa) m_a = r;
    if (nz) begin m_p[7] = r[7]; m_p[1] = (r == 8'h00); end
  endtask

  // Drivers: start and end right after a falling edge.
  task automatic drive_load(input logic pe, input logic [7:0] pd, input logic ae, input logic [7:0] ad);
    p_load_en = pe; p_load_data = pd; a_load_en = ae; a_load_data = ad;
    @(negedge clk);
    p_load_en = 1'b0; a_load_en = 1'b0;
    if (pe) m_p = pd | 8'h20;
    else if (ae) begin m_p[7] = ad[7]; m_p[1] = (ad == 8'h00); end
    if (ae) m_a = ad;
  endtask

  task automatic do_op(input logic [3:0] k, input logic [7:0] m, output int lat,
                       output logic [4:0] op1, output logic [7:0] a1, output logic [7:0] b1);
    req_valid = 1'b1; req_kind = k; req_operand = m;
    @(negedge clk);
    req_valid = 1'b0;
    op1 = alu_op; a1 = alu_reg_a; b1 = alu_reg_b;
    lat = 1;
    while (!done && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    if (!done) lat = -1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (acc !== 8'h00) begin errors++; $display("FAIL reset_acc: got %h expected 00", acc); end
    checks++; if (status !== 8'h20) begin errors++; $display("FAIL reset_status: got %h expected 20", status); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
    checks++; if ({alu_op, alu_reg_a, alu_reg_b} !== 21'h0) begin errors++;
      $display("FAIL reset_alu_drive: got op=%b a=%h b=%h expected zeros", alu_op, alu_reg_a, alu_reg_b); end
    checks++; if (alu_decimal_mode !== 1'b0) begin errors++; $display("FAIL reset_decimal: got %b expected 0", alu_decimal_mode); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1 || status !== 8'h20) begin errors++;
      $display("FAIL post_reset: got ready=%b status=%h expected 1/20", req_ready, status); end
  endtask

  task automatic test_loads();
    drive_load(1'b0, 8'h00, 1'b1, 8'h00);
    checks++; if (acc !== m_a || status !== m_p) begin errors++;
      $display("FAIL load_a_zero: got %h/%h expected %h/%h", acc, status, m_a, m_p); end
    drive_load(1'b1, 8'h00, 1'b1, 8'h80);
    checks++; if (acc !== m_a || status !== m_p) begin errors++;
      $display("FAIL load_both: got %h/%h expected %h/%h", acc, status, m_a, m_p); end
    drive_load(1'b0, 8'h00, 1'b1, 8'h80);
    checks++; if (acc !== m_a || status !== m_p) begin errors++;
      $display("FAIL load_a_neg: got %h/%h expected %h/%h", acc, status, m_a, m_p); end
    p_load_en = 1'b1; p_load_data = 8'h01;
    #1;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL ready_during_pload: got %b expected 0", req_ready); end
    @(negedge clk);
    p_load_en = 1'b0; m_p = 8'h21;
    checks++; if (status !== m_p || alu_carry_in !== 1'b1) begin errors++;
      $display("FAIL pload_carry: got %h/%b expected %h/1", status, alu_carry_in, m_p); end
  endtask

  task automatic test_adc_sbc();
    int lat, elat;
    logic [4:0] op1;
    logic [7:0] a1, b1;
    drive_load(1'b1, 8'h20, 1'b1, 8'h50);
    do_op(4'd0, 8'h50, lat, op1, a1, b1); ref_op(4'd0, 8'h50, elat);
    checks++; if (lat !== elat) begin errors++; $display("FAIL adc_latency: got %0d expected %0d", lat, elat); end
    checks++; if (op1 !== 5'b10000 || a1 !== 8'h50 || b1 !== 8'h50) begin errors++;
      $display("FAIL adc_s1_drive: got op=%b a=%h b=%h expected 10000/50/50", op1, a1, b1); end
    checks++; if (acc !== m_a || status !== m_p) begin errors++;
      $display("FAIL adc_overflow: got %h/%h expected %h/%h", acc, status, m_a, m_p); end
    drive_load(1'b1, 8'h21, 1'b1, 8'h80);
    do_op(4'd0, 8'hFF, lat, op1, a1, b1); ref_op(4'd0, 8'hFF, elat);
    checks++; if (acc !== m_a || status !== m_p) begin errors++;
      $display("FAIL adc_carry_in: got %h/%h expected %h/%h", acc, status, m_a, m_p); end
    drive_load(1'b1, 8'h21, 1'b1, 8'h50);
    do_op(4'd1, 8'h30, lat, op1, a1, b1); ref_op(4'd1, 8'h30, elat);
    checks++; if (lat !== elat || acc !== m_a || status !== m_p) begin errors++;
      $display("FAIL sbc: got lat=%0d %h/%h expected lat=%0d %h/%h", lat, acc, status, elat, m_a, m_p); end
  endtask

  task automatic test_cmp();
    int lat, elat;
    logic [4:0] op1;
    logic [7:0] a1, b1;
    drive_load(1'b1, 8'h20, 1'b1, 8'h10);
    do_op(4'd5, 8'h10, lat, op1, a1, b1); ref_op(4'd5, 8'h10, elat);
    checks++; if (lat !== elat || acc !== m_a || status !== m_p) begin errors++;
      $display("FAIL cmp_equal: got lat=%0d %h/%h expected lat=%0d %h/%h", lat, acc, status, elat, m_a, m_p); end
    do_op(4'd5, 8'h20, lat, op1, a1, b1); ref_op(4'd5, 8'h20, elat);
    checks++; if (acc !== m_a || status !== m_p) begin errors++;
      $display("FAIL cmp_less: got %h/%h expected %h/%h", acc, status, m_a, m_p); end
  endtask

  task automatic test_shifts();
    int lat, elat;
    logic [4:0] op1;
    logic [7:0] a1, b1;
    drive_load(1'b1, 8'h21, 1'b1, 8'h01);
    do_op(4'd9, 8'h00, lat, op1, a1, b1); ref_op(4'd9, 8'h00, elat);
    checks++; if (lat !== elat || acc !== m_a || status !== m_p) begin errors++;
      $display("FAIL ror: got lat=%0d %h/%h expected lat=%0d %h/%h", lat, acc, status, elat, m_a, m_p); end
    drive_load(1'b0, 8'h00, 1'b1, 8'h81);
    do_op(4'd7, 8'h00, lat, op1, a1, b1); ref_op(4'd7, 8'h00, elat);
    checks++; if (lat !== elat || acc !== m_a || status !== m_p) begin errors++;
      $display("FAIL lsr: got lat=%0d %h/%h expected lat=%0d %h/%h", lat, acc, status, elat, m_a, m_p); end
    drive_load(1'b1, 8'h20, 1'b1, 8'h80);
    do_op(4'd8, 8'h00, lat, op1, a1, b1); ref_op(4'd8, 8'h00, elat);
    checks++; if (lat !== elat || acc !== m_a || status !== m_p) begin errors++;
      $display("FAIL rol: got lat=%0d %h/%h expected lat=%0d %h/%h", lat, acc, status, elat, m_a, m_p); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] kinds [3];
    int n, idx, last, elat;
    bit pending;
    kinds[0] = 4'd2; kinds[1] = 4'd10; kinds[2] = 4'd11;
    drive_load(1'b1, 8'h21, 1'b1, 8'hFF);
    n = 0; idx = 0; last = -1; pending = 0;
    while ((idx < 3 || pending) && n < 40) begin
      if (done) begin
        checks++; if (acc !== m_a || status !== m_p) begin errors++;
          $display("FAIL b2b_result%0d: got %h/%h expected %h/%h", idx, acc, status, m_a, m_p); end
        pending = 0;
      end
      if (idx < 3 && req_ready) begin
        if (last >= 0) begin
          checks++; if (n - last != 2) begin errors++;
            $display("FAIL b2b_interval: got %0d expected 2", n - last); end
        end
        last = n;
        req_valid = 1'b1; req_kind = kinds[idx]; req_operand = 8'hFF;
        ref_op(kinds[idx], 8'hFF, elat);
        idx++; pending = 1;
      end else if (idx >= 3) begin
        req_valid = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    req_valid = 1'b0;
    checks++; if (idx != 3 || pending) begin errors++;
      $display("FAIL b2b_timeout: got idx=%0d pending=%0d expected 3/0", idx, pending); end
  endtask

  task automatic test_reset_mid_op();
    int seen;
    drive_load(1'b1, 8'h21, 1'b1, 8'h50);
    req_valid = 1'b1; req_kind = 4'd0; req_operand = 8'h50;
    @(negedge clk);
    req_valid = 1'b0;
    p_load_en = 1'b1; p_load_data = 8'hC3;
    @(negedge clk);
    p_load_en = 1'b0;
    checks++; if (status !== 8'h21 || acc !== 8'h50 || done !== 1'b0) begin errors++;
      $display("FAIL load_in_s1: got %h/%h done=%b expected 21/50 done=0", status, acc, done); end
    rst_n = 1'b0;
    #1;
    checks++; if (acc !== 8'h00 || status !== 8'h20 || req_ready !== 1'b1) begin errors++;
      $display("FAIL reset_mid_op: got %h/%h ready=%b expected 00/20 ready=1", acc, status, req_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    m_a = 8'h00; m_p = 8'h20;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (done) seen++;
      @(negedge clk);
    end
    checks++; if (seen != 0 || status !== 8'h20) begin errors++;
      $display("FAIL no_done_after_reset: got done_count=%0d status=%h expected 0/20", seen, status); end
  endtask

  task automatic test_random();
    int lat, elat;
    logic [4:0] op1;
    logic [7:0] a1, b1, m;
    logic [3:0] k;
    for (int i = 0; i < 40; i++) begin
      drive_load(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 8'($urandom));
      k = 4'($urandom_range(0, 15));
      m = 8'($urandom);
      do_op(k, m, lat, op1, a1, b1);
      ref_op(k, m, elat);
      checks++; if (lat !== elat) begin errors++;
        $display("FAIL rand_latency kind=%0d: got %0d expected %0d", k, lat, elat); end
      checks++; if (acc !== m_a) begin errors++;
        $display("FAIL rand_acc kind=%0d m=%h: got %h expected %h", k, m, acc, m_a); end
      checks++; if (status !== m_p) begin errors++;
        $display("FAIL rand_status kind=%0d m=%h: got %h expected %h", k, m, status, m_p); end
    end
  endtask

  initial begin
    test_reset();
    test_loads();
    test_adc_sbc();
    test_cmp();
    test_shifts();
    test_back_to_back();
    test_reset_mid_op();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Multi-cycle sequencer that sits between the instruction decoder and the combinational ALU (`alu`). It owns the accumulator A and the processor status register P. It accepts one accumulator-class operation per handshake and drives the ALU operand, op and carry inputs for one or two steps. It then captures the ALU result and commits A and the N/V/Z/C flags. The ALU's SUM ignores carry-in, so the sequencer applies the carry (ADC/SBC/ROL) as a second step and computes V itself.

## Interface
- No parameters.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: operation request.
- `req_ready` out 1: high only in IDLE with `p_load_en` low; accept = `req_valid && req_ready`.
- `req_kind` in 4: 0 ADC, 1 SBC, 2 AND, 3 ORA, 4 EOR, 5 CMP, 6 ASL, 7 LSR, 8 ROL, 9 ROR, 10 INC, 11 DEC; 12–15 illegal.
- `req_operand` in 8: memory operand M, sampled at accept.
- `p_load_en` in 1, `p_load_data` in 8: direct write of P (CLC/SEC/PLP path), honoured only in IDLE.
- `a_load_en` in 1, `a_load_data` in 8: direct write of A (LDA path), honoured only in IDLE; updates N and Z.
- `alu_reg_a` out 8, `alu_reg_b` out 8, `alu_op` out 5, `alu_carry_in` out 1, `alu_decimal_mode` out 1: ALU drive. `alu_op` is one-hot: SUM 10000, AND 01000, OR 00100, EOR 00010, SR 00001.
- `alu_hold_reg` in 8, `alu_overflow` in 1, `alu_carry_out` in 1: ALU results; `alu_overflow` is unused.
- `acc` out 8: A register.
- `status` out 8: P, bit order NV1BDIZC.
- `done` out 1: one-cycle pulse when the committed A/P become visible.

## Operation
- States: IDLE, S1, S2. Accept moves to S1. S1 moves to S2 for two-step ops, otherwise back to IDLE with commit. S2 always returns to IDLE with commit.
- At accept, latch kind, M, and A0 (current A) into internal registers; all steps use the latched values.
- Two-step ops and their steps:
  - ADC: S1 SUM(A0, M), capture r1/c1; S2 SUM(r1, {7'b0, C}).
  - SBC: as ADC with `~M` in place of M.
  - ROL: S1 SUM(A0, A0); S2 SUM(r1, C).
  - ROR: S1 SR(A0); S2 OR(r1, {C, 7'b0}).
- ADC/SBC flags:
  - C = c1 | c2.
  - V = ~(A0[7] ^ B[7]) & (A0[7] ^ R[7]), with B = M or ~M and R the final result.
- Single-step ops:
  - AND/ORA/EOR: ALU op (A0, M).
  - CMP: SUM(A0, ~M), then result+1 computed in the sequencer. C = carry-out of the 9-bit A0 + ~M + 1; A is not written.
  - ASL: SUM(A0, A0), C = carry_out.
  - LSR: SR(A0), C = A0[0]; the sequencer supplies C because the ALU returns 0.
  - INC: SUM(A0, 8'h01). DEC: SUM(A0, 8'hFF).
- Flags updated per op; all others hold:
  - ADC/SBC: N Z C V.
  - AND/ORA/EOR/INC/DEC: N Z.
  - CMP/ASL/LSR/ROL/ROR: N Z C.
- N = R[7]; Z = (R == 0).
- ROL C = A0[7]; ROR C = A0[0].
- Illegal kind: one S1 cycle, no A/P change, `done` still pulses.
- `alu_carry_in` is always driven with P.C. `alu_decimal_mode` is always 0; BCD is unsupported and P.D is stored only.
- P[5] reads 1 always; B/D/I change only via `p_load_en`.
- Priority in IDLE: `p_load_en` > `a_load_en` > request. When both loads are asserted, P is taken from `p_load_data` and A from `a_load_data`, and the A load's N/Z update is suppressed. Loads complete in one edge and do not pulse `done`.

## Timing
- Reset (async, `rst_n` low):
  - `acc` = 8'h00, `status` = 8'h20, `done` = 0, state IDLE (`req_ready` = 1).
  - While in IDLE: `alu_op` = 5'b00000, `alu_reg_a`/`alu_reg_b` = 0.
- Latency, with accept at edge E0:
  - Single-step: commit at E1; `done` = 1 and new `acc`/`status` visible in the cycle after E1.
  - Two-step: commit at E2.
- ALU outputs are registered state-decoded drives, stable for the full S1/S2 cycle. Results are sampled at the end of that cycle.
- `req_ready` is high in the `done` cycle, so back-to-back accepts give one op per 2 or 3 cycles.
- Reset mid-op: in-flight op is discarded, no `done`, A/P return to reset values.
- Load inputs asserted outside IDLE are ignored.

## Test plan
- ADC A=0x50, M=0x50, C=0 → A=0xA0, N=1, V=1, C=0, Z=0. `done` 3 cycles after the accept cycle; S1 shows `alu_op`=10000, reg_a=0x50, reg_b=0x50.
- ADC A=0x80, M=0xFF, C=1 → A=0x80, C=1, V=0 (checks that V is not the OR of the per-step ALU V); then SBC A=0x50, M=0x30, C=1 → A=0x20, C=1, V=0.
- CMP A=0x10, M=0x10 → A unchanged 0x10, Z=1, C=1, N=0; then CMP M=0x20 → Z=0, C=0, N=1.
- A=0x01, C=1: ROR → A=0x80, C=1, N=1; LSR on A=0x81 → A=0x40, C=1; ROL on A=0x80 with C=0 → A=0x00, Z=1, C=1.
- Back-to-back AND, INC, DEC held on `req_valid`: accepts every 2 cycles. INC from 0xFF → 0x00, Z=1, C unchanged.
- Assert `rst_n`=0 during S2 of an ADC → no `done`, `acc`=0x00, `status`=0x20, `req_ready`=1 immediately. A `p_load_en` issued during S1 is ignored.
